// File: rtl/freq_meter_autorange.sv
// Gated edge-counting frequency meter with decade auto-ranging on a single clock.
// Optional manual range selection is enabled by defining FREQM_MANUAL_RANGE_EN.
module freq_meter_autorange #(
  parameter int CNT_W      = 16,
  parameter int CLK_PER_MS = 50000,
  parameter int NUM_RANGES = 4,
  parameter int LOW_THRESH = 4096,
  localparam int RANGE_W   = (NUM_RANGES > 1) ? $clog2(NUM_RANGES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sig,
`ifdef FREQM_MANUAL_RANGE_EN
  input  logic               auto_n,
  input  logic [RANGE_W-1:0] range_sel,
`endif
  output logic [CNT_W-1:0]   freq_count,
  output logic [RANGE_W-1:0] range,
  output logic               ovf,
  output logic               valid,
  output logic               busy
);

  function automatic int pow10(input int e);
    int p;
    p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  localparam int PRE_W  = $clog2(CLK_PER_MS);
  localparam int GATE_W = $clog2(pow10(NUM_RANGES - 1) + 1);
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(CLK_PER_MS - 1);
  localparam logic [RANGE_W-1:0] R_MAX    = RANGE_W'(NUM_RANGES - 1);

  // Gate length in ms ticks for a range, built as a constant lookup (no multiplier).
  function automatic logic [GATE_W-1:0] dec_len(input logic [RANGE_W-1:0] r);
    logic [GATE_W-1:0] v;
    int p;
    v = '0;
    p = 1;
    for (int i = 0; i < NUM_RANGES; i++) begin
      if (r == RANGE_W'(i)) v = GATE_W'(p);
      p = p * 10;
    end
    return v;
  endfunction

  typedef enum logic [1:0] {IDLE, GATE, EVAL} state_t;

  state_t             state;
  logic               sync1, sync2, hist;
  logic [RANGE_W-1:0] r_int;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_int;
  logic [PRE_W-1:0]   pre;
  logic [GATE_W-1:0]  gcnt;

  logic               sig_rise, step_up, step_down, gate_done;
  logic [RANGE_W-1:0] next_range, entry_range;

  assign sig_rise  = sync2 & ~hist;
  assign gate_done = (pre == PRE_LAST) && (gcnt == dec_len(r_int) - GATE_W'(1));

  always_comb begin
    step_down = ovf_int && (r_int != '0);
    step_up   = !ovf_int && (cnt < CNT_W'(LOW_THRESH)) && (r_int < R_MAX);
`ifdef FREQM_MANUAL_RANGE_EN
    if (auto_n) begin
      step_down = 1'b0;
      step_up   = 1'b0;
    end
`endif
    if (state == EVAL && step_down)    next_range = r_int - 1'b1;
    else if (state == EVAL && step_up) next_range = r_int + 1'b1;
    else                               next_range = r_int;
    entry_range = next_range;
`ifdef FREQM_MANUAL_RANGE_EN
    if (auto_n) entry_range = (range_sel > R_MAX) ? R_MAX : range_sel;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      hist       <= 1'b0;
      r_int      <= '0;
      cnt        <= '0;
      ovf_int    <= 1'b0;
      pre        <= '0;
      gcnt       <= '0;
      freq_count <= '0;
      range      <= '0;
      ovf        <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync1 <= sig;
      sync2 <= sync1;
      hist  <= sync2;
      valid <= 1'b0;
      if (!en) begin
        // Abort: partial gate is dropped, published results and r_int hold.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, EVAL: begin
            if (state == EVAL && !step_down && !step_up) begin
              freq_count <= cnt;
              range      <= r_int;
              ovf        <= ovf_int;
              valid      <= 1'b1;
            end
            state   <= GATE;
            busy    <= 1'b1;
            r_int   <= entry_range;
            cnt     <= '0;
            ovf_int <= 1'b0;
            pre     <= '0;
            gcnt    <= '0;
          end
          GATE: begin
            if (sig_rise) begin
              if (&cnt) ovf_int <= 1'b1;
              else      cnt     <= cnt + 1'b1;
            end
            if (pre == PRE_LAST) begin
              pre  <= '0;
              gcnt <= gcnt + 1'b1;
            end else begin
              pre <= pre + 1'b1;
            end
            if (gate_done) begin
              state <= EVAL;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_autorange.sv
// Bench for freq_meter_autorange: directed steps plus random periods checked
// against an arithmetic model of gate length, expected edge count and range choice.
module tb_freq_meter_autorange;
  localparam int CNT_W      = 8;
  localparam int CLK_PER_MS = 10;
  localparam int NUM_RANGES = 3;
  localparam int LOW_THRESH = 20;
  localparam int RANGE_W    = 2;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               sig = 1'b0;
`ifdef FREQM_MANUAL_RANGE_EN
  logic               auto_n = 1'b0;
  logic [RANGE_W-1:0] range_sel = '0;
`endif
  logic [CNT_W-1:0]   freq_count;
  logic [RANGE_W-1:0] range;
  logic               ovf, valid, busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int per = 4;
  int ph = 0;
  int dbl = 0;
  logic prev_valid = 1'b0;
  int q_cnt[$], q_rng[$], q_ovf[$], q_cyc[$];
  logic [RANGE_W-1:0] exp_q[$];

  freq_meter_autorange #(
    .CNT_W(CNT_W), .CLK_PER_MS(CLK_PER_MS), .NUM_RANGES(NUM_RANGES), .LOW_THRESH(LOW_THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig(sig),
`ifdef FREQM_MANUAL_RANGE_EN
    .auto_n(auto_n), .range_sel(range_sel),
`endif
    .freq_count(freq_count), .range(range), .ovf(ovf), .valid(valid), .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // periodic sig source, changes on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      ph = ph + 1;
      if (ph >= per) ph = 0;
      sig = (ph < per / 2);
    end
  end

  // publish monitor
  always @(negedge clk) begin
    cyc++;
    if (valid === 1'b1) begin
      q_cnt.push_back(int'(freq_count));
      q_rng.push_back(int'(range));
      q_ovf.push_back(int'(ovf));
      q_cyc.push_back(cyc);
      if (prev_valid) dbl++;
    end
    prev_valid = valid;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int g, input int p);
    int d;
    d = obs * p - g;
    if (d < 0) d = -d;
    total++;
    assert (d < p) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d/%0d within 1", tag, obs, g, p);
    end
  endtask

  task automatic wait_pub(input int budget, output int c, output int r, output int o, output int t);
    int n;
    n = 0;
    while (q_cnt.size() == 0 && n < budget) begin
      step();
      n++;
    end
    total++;
    assert (q_cnt.size() > 0) else begin
      bad++;
      $error("FAIL pub_timeout: got no valid within %0d cycles want one", budget);
    end
    if (q_cnt.size() > 0) begin
      c = q_cnt.pop_front();
      r = q_rng.pop_front();
      o = q_ovf.pop_front();
      t = q_cyc.pop_front();
    end else begin
      c = -1; r = -1; o = -1; t = -1;
    end
  endtask

  // abort, swap period, let the synchroniser settle, re-enable; returns re-enable cycle
  task automatic switch_period(input int p, output int t_en);
    en = 1'b0;
    per = p;
    ph = 0;
    repeat (8) step();
    q_cnt.delete(); q_rng.delete(); q_ovf.delete(); q_cyc.delete();
    en = 1'b1;
    t_en = cyc;
  endtask

  // reference model
  function automatic int gate_len(input int r);
    int g;
    g = CLK_PER_MS;
    for (int i = 0; i < r; i++) g = g * 10;
    return g;
  endfunction

  function automatic int model_range(input int r0, input int p);
    int r, n;
    r = r0;
    for (int k = 0; k < 2 * NUM_RANGES; k++) begin
      n = gate_len(r) / p;
      if (n > CNT_MAX && r > 0) r = r - 1;
      else if (n < LOW_THRESH && r < NUM_RANGES - 1) r = r + 1;
      else return r;
    end
    return r;
  endfunction

  function automatic bit ambiguous(input int p);
    int n;
    for (int r = 0; r < NUM_RANGES; r++) begin
      n = gate_len(r) / p;
      if (n >= LOW_THRESH - 2 && n <= LOW_THRESH + 1) return 1'b1;
      if (n >= CNT_MAX - 3 && n <= CNT_MAX + 3) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    int c, r, o, t, t0, t_en, p, er, ec, eo;
    logic [CNT_W-1:0]   s_cnt;
    logic [RANGE_W-1:0] s_rng;

    // reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_count", freq_count, 0);
    chk("rst_range", range, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // step-up: period 4, range 0 discarded, range 1 publishes 25
    en = 1'b1;
    t_en = cyc;
    wait_pub(400, c, r, o, t);
    chk("up_range", r, 1);
    chk_near("up_count", c, 100, 4);
    chk("up_ovf", o, 0);
    chk("up_latency", t - t_en, 113);
    step();
    chk("up_pulse", valid, 0);
    t0 = t;
    wait_pub(200, c, r, o, t);
    chk("up_interval", t - t0, 101);
    chk_near("up_count2", c, 100, 4);

    // reset mid-gate with sig toggling
    repeat (30) step();
    q_cnt.delete(); q_rng.delete(); q_ovf.delete(); q_cyc.delete();
    rst_n = 1'b0;
    repeat (3) step();
    chk("mid_rst_count", freq_count, 0);
    chk("mid_rst_range", range, 0);
    chk("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    en = 1'b0;
    repeat (150) step();
    chk("idle_no_valid", q_cnt.size(), 0);
    chk("idle_busy", busy, 0);
    en = 1'b1;
    t_en = cyc;
    wait_pub(400, c, r, o, t);
    chk("rearm_latency", t - t_en, 113);
    chk("rearm_range", r, 1);

    // top range with low count
    switch_period(200, t_en);
    wait_pub(3000, c, r, o, t);
    chk("top_range", r, 2);
    chk_near("top_count", c, 1000, 200);
    chk("top_ovf", o, 0);

    // step-down from range 2 with period 2
    switch_period(2, t_en);
    wait_pub(3000, c, r, o, t);
    chk("down_range", r, 1);
    chk_near("down_count", c, 100, 2);
    chk("down_ovf", o, 0);
    chk("down_latency", t - t_en, 1000 + 1 + 100 + 2);

    // abort for one cycle mid-gate
    repeat (30) step();
    s_cnt = freq_count;
    s_rng = range;
    en = 1'b0;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_hold_count", freq_count, s_cnt);
    chk("abort_hold_range", range, s_rng);
    en = 1'b1;
    t_en = cyc;
    wait_pub(400, c, r, o, t);
    chk("abort_latency", t - t_en, 102);
    chk("abort_range", r, 1);

    // exactly LOW_THRESH stays in band at range 1
    switch_period(5, t_en);
    wait_pub(400, c, r, o, t);
    chk("thresh_range", r, 1);
    chk("thresh_count", c, LOW_THRESH);

    // random periods against the model
    for (int k = 0; k < 6; k++) begin
      er = r;
      do p = $urandom_range(300, 2); while (ambiguous(p));
      er = model_range(er, p);
      exp_q.push_back(er[RANGE_W-1:0]);
      ec = gate_len(er) / p;
      eo = (ec > CNT_MAX) ? 1 : 0;
      switch_period(p, t_en);
      wait_pub(4000, c, r, o, t);
      chk($sformatf("rnd%0d_p%0d_range", k, p), r, exp_q.pop_front());
      chk($sformatf("rnd%0d_ovf", k), o, eo);
      if (eo == 1) chk($sformatf("rnd%0d_count", k), c, CNT_MAX);
      else chk_near($sformatf("rnd%0d_count", k), c, gate_len(er), p);
      t0 = t;
      wait_pub(1500, c, r, o, t);
      chk($sformatf("rnd%0d_interval", k), t - t0, gate_len(er) + 1);
    end

`ifdef FREQM_MANUAL_RANGE_EN
    // manual range 2 with period 2 saturates and never steps down
    auto_n = 1'b1;
    range_sel = 2'd2;
    switch_period(2, t_en);
    wait_pub(1500, c, r, o, t);
    chk("man_range", r, 2);
    chk("man_count", c, CNT_MAX);
    chk("man_ovf", o, 1);
    t0 = t;
    wait_pub(1500, c, r, o, t);
    chk("man_interval", t - t0, 1001);
    chk("man_range2", r, 2);
    range_sel = 2'd3;
    switch_period(40, t_en);
    wait_pub(1500, c, r, o, t);
    chk("man_clamp_range", r, 2);
    chk_near("man_clamp_count", c, 1000, 40);
    auto_n = 1'b0;
`endif

    chk("valid_single_cycle", dbl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_meter_autorange.md
Name: freq_meter_autorange

Overview:
- Gated edge-counting frequency meter with decade auto-ranging.
- Replaces the fixed 16-bit, two-range counter/divider scheme.
- Counts rising edges of an asynchronous input `sig` over a gate of `CLK_PER_MS * 10^range` clock cycles. Range steps up or down until the count is in band, then publishes count and range to the display/readout logic.
- Everything runs on the single system clock; `sig` is never used as a clock.

Parameters:
- CNT_W, 16, edge counter and result width; count saturates at 2^CNT_W-1.
- CLK_PER_MS, 50000, clk cycles per millisecond (gate base unit); >=2.
- NUM_RANGES, 4, number of decade ranges; gate for range r = 10^r ms; 1..6.
- LOW_THRESH, 4096, in-band lower limit; must satisfy LOW_THRESH*10 < 2^CNT_W.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  1 = measure continuously; 0 = abort and idle.
- sig  in  1  asynchronous signal under measurement.
- freq_count  out  CNT_W  last published edge count.
- range  out  RANGE_W  range of published count; RANGE_W = max(1, clog2(NUM_RANGES)).
- ovf  out  1  published count saturated.
- valid  out  1  one-cycle pulse when freq_count/range/ovf update.
- busy  out  1  high while a gate is open.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at posedge): state IDLE. All of the following clear to 0: freq_count, range, ovf, valid, busy, internal range register, edge counter, prescaler, gate counter, sync flops. Reset wins over every other input.
- Input sync: `sig` passes through 2 flops plus a history flop. An edge is recognised when sync2=1 and hist=0. Max measurable rate < clk/2. Edge latency of 3 cycles is accepted; no compensation.
- FSM states: IDLE, GATE, EVAL.
  - IDLE: busy=0. On en=1, clear edge counter, prescaler and gate counter, then go to GATE.
  - GATE: busy=1. The prescaler counts 0..CLK_PER_MS-1; each wrap is one ms tick. The gate counter counts ms ticks up to 10^r_int. The gate lasts exactly CLK_PER_MS*10^r_int cycles. Edges are counted on every GATE cycle, saturating at all-ones with a sticky internal ovf.
  - EVAL: lasts one cycle. The decision uses the gate count c and the internal range r_int:
    - ovf and r_int>0: r_int-1, discard result, go to GATE.
    - !ovf and c<LOW_THRESH and r_int<NUM_RANGES-1: r_int+1, discard result, go to GATE.
    - Otherwise publish freq_count=c, range=r_int, ovf, valid=1 for this cycle only, then go to GATE with the same range.
- Boundaries:
  - Overflow at range 0 publishes all-ones with ovf=1.
  - Low count at the top range publishes as-is.
  - Count exactly LOW_THRESH is in band.
- Every transition into GATE clears the edge counter, ovf, prescaler and gate counter. There is no dead time beyond the EVAL cycle.
- en=0 in GATE or EVAL: go to IDLE next cycle, discard the partial gate, no valid. Published outputs and r_int hold. Re-enabling resumes at the held r_int.
- Published outputs change only on a valid cycle or on reset.
- Gate counter width covers 10^(NUM_RANGES-1). The decade length is derived from a constant function or lookup of r_int; no runtime multiplier.

Optional Feature:
- Macro: FREQM_MANUAL_RANGE_EN.
- Defined: adds input ports `auto_n` (1 bit) and `range_sel` (RANGE_W bits).
  - With auto_n=1, r_int is loaded from range_sel (clamped to NUM_RANGES-1) at every entry to GATE. EVAL always publishes, with no step up or down; ovf is reported as-is.
  - With auto_n=0, behaviour is identical to the auto-ranging mode.
- Undefined: neither port exists; behaviour is always auto-ranging.

Test Plan (CNT_W=8, CLK_PER_MS=10, NUM_RANGES=3, LOW_THRESH=20; gates are 10/100/1000 cycles):
- Reset: rst_n=0 for 3 cycles mid-gate, with sig toggling -> all outputs 0, busy=0, no valid until en re-asserted.
- Step-up: en=1, sig period 4 clk -> range 0 gives <=3 edges and is discarded; range 1 publishes freq_count=25±1, range=1, ovf=0, with valid a single-cycle pulse. Repeats every 101 cycles.
- Top range low count: sig period 200 clk -> steps up twice, then publishes freq_count=5±1, range=2, ovf=0.
- Step-down: from the previous case, switch sig to period 2 -> range 2 saturates (255, ovf) and is discarded; range 1 publishes freq_count=50±1, range=1, ovf=0.
- Abort: drop en for 1 cycle mid-gate -> IDLE, busy=0, no valid, outputs held. Re-enable -> next valid comes after a full gate at the held range.
- Manual (FREQM_MANUAL_RANGE_EN): auto_n=1, range_sel=2, sig period 2 -> publishes 255, ovf=1, range=2 each 1001 cycles; no step-down.
